// File: rtl/rgb_sched_pkg.sv
// Shared types, channel indices and the optional perceptual duty curve for the RGB LED scheduler.
// The curve is only used when RGB_SCHED_GAMMA_EN is defined.
package rgb_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } sched_state_e;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int N_CH = 3;

    // Quadratic curve, rounded up so 1 maps to 1 and full scale maps to full scale.
    function automatic logic [31:0] gamma_curve(input logic [15:0] x, input int unsigned bits);
        logic [31:0] sq;
        sq = 32'(x) * 32'(x);
        return (sq + ((32'd1 << bits) - 32'd1)) >> bits;
    endfunction

endpackage

// File: rtl/rgb_pwm_core.sv
// PWM timebase for the RGB LED: prescaler, frame counter, frame boundary strobe
// and three registered duty comparators.
import rgb_sched_pkg::*;

module rgb_pwm_core #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 195
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic [N_CH-1:0][PWM_BITS-1:0] duty,
    input  logic                          en,
    output logic [N_CH-1:0]               led_pwm,
    output logic                          frame_tick,
    output logic                          fb
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step;

    assign step = (prescaler == PS_LAST);
    assign fb   = step && (pwm_cnt == '1);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            pwm_cnt    <= '0;
            frame_tick <= 1'b0;
            led_pwm    <= '0;
        end else begin
            prescaler  <= step ? '0 : prescaler + PS_W'(1);
            if (step) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            frame_tick <= fb;
            // Compare against the current count so outputs trail pwm_cnt by one clock.
            for (int c = 0; c < N_CH; c++) begin
                led_pwm[c] <= en && (pwm_cnt < duty[c]);
            end
        end
    end

endmodule

// File: rtl/rgb_led_scheduler.sv
// Shares the RGB LED among N_REQ requesters with frame-aligned fixed-priority arbitration.
// Define RGB_SCHED_GAMMA_EN to map colours through a quadratic perceptual curve.
import rgb_sched_pkg::*;

module rgb_led_scheduler #(
    parameter int N_REQ       = 4,
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 195,
    parameter int HOLD_FRAMES = 64
) (
    input  logic                        clk_50m,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*3*PWM_BITS-1:0] color,
    output logic [N_REQ-1:0]            grant,
    output logic [2:0]                  led_pwm,
    output logic                        led_en,
    output logic                        frame_tick
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 3 * PWM_BITS;

    sched_state_e                  state_q, state_n;
    logic [OW-1:0]                 owner_q, owner_n;
    logic [7:0]                    hold_q, hold_n;
    logic [N_REQ-1:0]              grant_n;
    logic [N_CH-1:0][PWM_BITS-1:0] duty_q, duty_n;
    logic [OW-1:0]                 lowest;
    logic                          any_req;
    logic                          lower_pending;
    logic                          fb;
    logic [PWM_BITS-1:0]           x;

    rgb_pwm_core #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_pwm (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .duty       (duty_q),
        .en         (led_en),
        .led_pwm    (led_pwm),
        .frame_tick (frame_tick),
        .fb         (fb)
    );

    always_comb begin
        lowest        = '0;
        any_req       = |req;
        lower_pending = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lowest = OW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (i < int'(owner_q))) begin
                lower_pending = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        hold_n  = hold_q;
        grant_n = '0;
        duty_n  = '0;
        x       = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_n = OWN;
                    owner_n = lowest;
                    hold_n  = 8'd0;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    // Owner released: hand over to the best pending request, hold ignored.
                    hold_n = 8'd0;
                    if (any_req) begin
                        owner_n = lowest;
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                    end
                end else if (lower_pending && (hold_q >= 8'(HOLD_FRAMES))) begin
                    owner_n = lowest;
                    hold_n  = 8'd0;
                end else if (hold_q != 8'hFF) begin
                    hold_n = hold_q + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
                hold_n  = 8'd0;
            end
        endcase

        if (state_n == OWN) begin
            grant_n[owner_n] = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                x = color[int'(owner_n) * CW + c * PWM_BITS +: PWM_BITS];
`ifdef RGB_SCHED_GAMMA_EN
                duty_n[c] = PWM_BITS'(gamma_curve(16'(x), PWM_BITS));
`else
                duty_n[c] = x;
`endif
            end
        end
    end

    // Everything the LED shows changes only on the frame boundary.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            hold_q  <= 8'd0;
            grant   <= '0;
            led_en  <= 1'b0;
            duty_q  <= '0;
        end else if (fb) begin
            state_q <= state_n;
            owner_q <= owner_n;
            hold_q  <= hold_n;
            grant   <= grant_n;
            led_en  <= (state_n == OWN);
            duty_q  <= duty_n;
        end
    end

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Frame-level bench for rgb_led_scheduler: counts PWM high time per frame and checks
// ownership decisions against a behavioural arbitration model.
module tb_rgb_led_scheduler;

    localparam int N_REQ    = 4;
    localparam int PWM_BITS = 8;
    localparam int PRESCALE = 2;
    localparam int HOLD     = 2;
    localparam int FRAME    = PRESCALE * (1 << PWM_BITS);

    logic        clk_50m;
    logic        rst_n;
    logic [3:0]  req;
    logic [95:0] color;
    logic [3:0]  grant;
    logic [2:0]  led_pwm;
    logic        led_en;
    logic        frame_tick;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model: owner (-1 = idle), frames held, duty in force for the current frame.
    int m_owner = -1;
    int m_hold  = 0;
    int m_duty [3];

    rgb_led_scheduler #(
        .N_REQ       (N_REQ),
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (PRESCALE),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .req        (req),
        .color      (color),
        .grant      (grant),
        .led_pwm    (led_pwm),
        .led_en     (led_en),
        .frame_tick (frame_tick)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic int curve(input int v);
`ifdef RGB_SCHED_GAMMA_EN
        return (v * v + 255) >> 8;
`else
        return v;
`endif
    endfunction

    function automatic logic [95:0] set_slot(input logic [95:0] base, input int idx,
                                             input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        logic [95:0] v;
        v = base;
        v[idx*24 +: 24] = {b, g, r};
        return v;
    endfunction

    function automatic int lowest_set(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        return -1;
    endfunction

    // Decide ownership at a frame boundary from the request/colour seen there.
    task automatic model_boundary(input logic [3:0] r, input logic [95:0] c);
        int lo;
        lo = lowest_set(r);
        if (m_owner < 0) begin
            if (lo >= 0) begin m_owner = lo; m_hold = 0; end
        end else if (!r[m_owner]) begin
            m_owner = lo;
            m_hold  = 0;
        end else if (lo < m_owner && m_hold >= HOLD) begin
            m_owner = lo;
            m_hold  = 0;
        end else begin
            m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
        end
        for (int ch = 0; ch < 3; ch++) begin
            logic [7:0] v;
            v = (m_owner < 0) ? 8'd0 : c[m_owner*24 + ch*8 +: 8];
            m_duty[ch] = curve(int'(v));
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        for (int ch = 0; ch < 3; ch++) m_duty[ch] = 0;
    endtask

    // Called at the negedge where frame_tick is high; runs exactly one frame.
    task automatic run_frame(input string tag, input logic [3:0] r, input logic [95:0] c,
                             input bit mid, input logic [95:0] c_mid);
        int hi [3];
        int ft;
        int eg;
        hi = '{0, 0, 0};
        ft = 0;
        req = r;
        color = c;
        for (int j = 1; j <= FRAME; j++) begin
            @(negedge clk_50m);
            if (mid && j == FRAME / 2) color = c_mid;
            for (int ch = 0; ch < 3; ch++) if (led_pwm[ch]) hi[ch]++;
            if (frame_tick) ft++;
        end
        check({tag, " r_high"}, hi[0], PRESCALE * m_duty[0]);
        check({tag, " g_high"}, hi[1], PRESCALE * m_duty[1]);
        check({tag, " b_high"}, hi[2], PRESCALE * m_duty[2]);
        check({tag, " ticks"}, ft, 1);
        check({tag, " tick_at_end"}, int'(frame_tick), 1);
        model_boundary(r, color);
        eg = (m_owner < 0) ? 0 : (1 << m_owner);
        check({tag, " grant"}, int'(grant), eg);
        check({tag, " led_en"}, int'(led_en), (m_owner >= 0) ? 1 : 0);
    endtask

    task automatic wait_tick(input string tag);
        int seen;
        seen = 0;
        for (int j = 0; j < 3 * FRAME && !seen; j++) begin
            @(negedge clk_50m);
            if (frame_tick) seen = 1;
        end
        check({tag, " tick_seen"}, seen, 1);
        if (!seen) begin
            $display("FAIL %s: no frame_tick, stopping", tag);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $fatal(1, "no frame timing");
        end
    endtask

    initial begin
        logic [95:0] col;
        logic [95:0] col2;
        logic [3:0]  rr;

        rst_n = 1'b0;
        req   = '0;
        color = '0;
        model_reset();
        repeat (3) @(negedge clk_50m);
        check("rst grant", int'(grant), 0);
        check("rst led_en", int'(led_en), 0);
        check("rst led_pwm", int'(led_pwm), 0);
        check("rst frame_tick", int'(frame_tick), 0);
        rst_n = 1'b1;
        wait_tick("sync0");

        // Idle frames
        for (int k = 0; k < 3; k++) run_frame("idle", 4'b0000, '0, 1'b0, '0);

        // Single requester 2, R=0x40 G=0 B=0xFF
        col = set_slot('0, 2, 8'h40, 8'h00, 8'hFF);
        run_frame("own2_a", 4'b0100, col, 1'b0, '0);
        run_frame("own2_b", 4'b0100, col, 1'b0, '0);

        // Higher priority waits out the hold time
        col = set_slot(col, 0, 8'hFF, 8'h10, 8'h01);
        for (int k = 0; k < 4; k++) run_frame("preempt", 4'b0101, col, 1'b0, '0);

        // Owner 0 drops with 1 and 3 pending, then everything drops
        col = set_slot(col, 1, 8'h20, 8'hC0, 8'h05);
        col = set_slot(col, 3, 8'h77, 8'h88, 8'h99);
        run_frame("drop", 4'b1010, col, 1'b0, '0);
        run_frame("to_idle", 4'b0000, col, 1'b0, '0);
        run_frame("idle2", 4'b0000, col, 1'b0, '0);

        // Live colour change mid-frame
        col  = set_slot('0, 0, 8'h10, 8'h00, 8'h00);
        col2 = set_slot('0, 0, 8'h80, 8'h00, 8'h00);
        run_frame("live_a", 4'b0001, col, 1'b0, '0);
        run_frame("live_b", 4'b0001, col, 1'b1, col2);
        run_frame("live_c", 4'b0001, col2, 1'b0, '0);

        // Curve points 128, 1, 255
        run_frame("curve128", 4'b0001, set_slot('0, 0, 8'd128, 8'd1, 8'd255), 1'b0, '0);
        run_frame("curve1", 4'b0001, set_slot('0, 0, 8'd1, 8'd255, 8'd0), 1'b0, '0);
        run_frame("curve255", 4'b0001, set_slot('0, 0, 8'd255, 8'd0, 8'd128), 1'b0, '0);

        // Asynchronous reset mid-frame while owning
        repeat (100) @(negedge clk_50m);
        #3 rst_n = 1'b0;
        #1;
        check("arst grant", int'(grant), 0);
        check("arst led_en", int'(led_en), 0);
        check("arst led_pwm", int'(led_pwm), 0);
        check("arst frame_tick", int'(frame_tick), 0);
        req = '0;
        @(negedge clk_50m);
        rst_n = 1'b1;
        model_reset();
        wait_tick("sync1");

        // Randomized frames
        for (int k = 0; k < 16; k++) begin
            rr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) rr = 4'b0000;
            col  = {$urandom, $urandom, $urandom};
            col2 = {$urandom, $urandom, $urandom};
            run_frame("rand", rr, col, 1'($urandom_range(0, 1)), col2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
